// File: rtl/memory_control_interfaces.sv
// ============================================================================
// Module : memory_control_interfaces (package)
// Brief  : Shared memory status codes and FIFO occupancy flag types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package memory_control_interfaces;

  typedef enum logic [1:0] {
    MEMORY_READY               = 2'd0,
    MEMORY_WAIT                = 2'd1,
    MEMORY_ERROR_OUT_OF_BOUNDS = 2'd2
  } memory_status_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t c_flags_clear = '{
    full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1
  };

  function automatic fifo_flags_t fifo_flags_calc(input int cnt, input int depth,
                                                  input int af_level, input int ae_level);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= af_level);
    f.almost_empty = (cnt <= ae_level);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_storage.sv
// ============================================================================
// Module : sync_fifo_storage
// Brief  : Un-reset flop array, one write port, combinational read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_storage #(
  parameter int word_size  = 16,
  parameter int word_count = 128,
  localparam int c_addr_w  = $clog2(word_count)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [c_addr_w-1:0]  waddr,
  input  logic [word_size-1:0] wdata,
  input  logic [c_addr_w-1:0]  raddr,
  output logic [word_size-1:0] rdata
);

  logic [word_size-1:0] r_mem [word_count];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with registered flags/status, FWFT or registered read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import memory_control_interfaces::*;

module sync_fifo #(
  parameter int word_size          = 16,
  parameter int word_count         = 128,
  parameter int almost_full_level  = word_count - 4,
  parameter int almost_empty_level = 4,
  parameter int fwft               = 1,
  localparam int c_addr_w          = $clog2(word_count),
  localparam int c_ptr_w           = c_addr_w + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 w,
  input  logic [word_size-1:0] wdata,
  input  logic                 r,
  output logic [word_size-1:0] rdata,
  output logic                 rvalid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [c_ptr_w-1:0]   count,
  output memory_status_t       status
);

  if ((word_count & (word_count - 1)) != 0 || word_count < 4) begin : g_err_depth
    $error("sync_fifo: word_count must be a power of 2 and at least 4");
  end
  if (word_size < 1 || word_size > 256) begin : g_err_width
    $error("sync_fifo: word_size must be 1..256");
  end
  if (almost_full_level > word_count) begin : g_err_af
    $error("sync_fifo: almost_full_level exceeds word_count");
  end
  if (almost_empty_level >= almost_full_level) begin : g_err_ae
    $error("sync_fifo: almost_empty_level must be below almost_full_level");
  end

  logic [c_ptr_w-1:0]   r_wptr, r_rptr;
  fifo_flags_t          r_flags;
  memory_status_t       r_status;

  logic                 w_wr_ok, w_rd_ok;
  logic [c_ptr_w-1:0]   w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic [word_size-1:0] w_head;

  // Acceptance uses only the registered flags, so a full FIFO refuses a write
  // even when a read drains a slot in the same cycle.
  assign w_wr_ok     = w && !r_flags.full;
  assign w_rd_ok     = r && !r_flags.empty;
  assign w_wptr_nxt  = r_wptr + {{(c_ptr_w-1){1'b0}}, w_wr_ok};
  assign w_rptr_nxt  = r_rptr + {{(c_ptr_w-1){1'b0}}, w_rd_ok};
  assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

  sync_fifo_storage #(
    .word_size  (word_size),
    .word_count (word_count)
  ) u_storage (
    .clk   (clk),
    .we    (w_wr_ok && !flush),
    .waddr (r_wptr[c_addr_w-1:0]),
    .wdata (wdata),
    .raddr (r_rptr[c_addr_w-1:0]),
    .rdata (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_flags  <= c_flags_clear;
      r_status <= MEMORY_READY;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_flags  <= c_flags_clear;
      r_status <= MEMORY_READY;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_flags <= fifo_flags_calc(int'(w_count_nxt), word_count,
                                 almost_full_level, almost_empty_level);
      if (w && r_flags.full)
        r_status <= MEMORY_ERROR_OUT_OF_BOUNDS;
      else if (r && r_flags.empty)
        r_status <= MEMORY_WAIT;
      else
        r_status <= MEMORY_READY;
    end
  end

  if (fwft == 0) begin : g_reg_read
    logic [word_size-1:0] r_rdata;
    logic                 r_rvalid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else if (flush) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_ok;
        if (w_rd_ok) r_rdata <= w_head;
      end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
  end else begin : g_fwft_read
    // Storage is never reset, so mask the head while empty to present zero.
    assign rdata  = r_flags.empty ? '0 : w_head;
    assign rvalid = !r_flags.empty;
  end

  assign count        = r_wptr - r_rptr;
  assign full         = r_flags.full;
  assign empty        = r_flags.empty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign status       = r_status;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module : tb_sync_fifo
// Brief  : Directed bench; FWFT and registered-read instances share stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import memory_control_interfaces::*;

module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        w = 1'b0;
  logic        r = 1'b0;
  logic [15:0] wdata = '0;

  logic [15:0] rdata_f, rdata_g;
  logic        rvalid_f, rvalid_g;
  logic        full_f, empty_f, af_f, ae_f;
  logic        full_g, empty_g, af_g, ae_g;
  logic [3:0]  count_f, count_g;
  memory_status_t status_f, status_g;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .word_size(16), .word_count(8), .almost_full_level(6),
    .almost_empty_level(2), .fwft(1)
  ) u_dut_fwft (
    .clk(clk), .reset(reset), .flush(flush), .w(w), .wdata(wdata), .r(r),
    .rdata(rdata_f), .rvalid(rvalid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f), .status(status_f)
  );

  sync_fifo #(
    .word_size(16), .word_count(8), .almost_full_level(6),
    .almost_empty_level(2), .fwft(0)
  ) u_dut_reg (
    .clk(clk), .reset(reset), .flush(flush), .w(w), .wdata(wdata), .r(r),
    .rdata(rdata_g), .rvalid(rvalid_g), .full(full_g), .empty(empty_g),
    .almost_full(af_g), .almost_empty(ae_g), .count(count_g), .status(status_g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] d);
    w = wr; r = rd; wdata = d;
    @(posedge clk); #1;
    w = 1'b0; r = 1'b0;
  endtask

  initial begin
    #12 reset = 1'b0;
    check("rst_count", 32'(count_f), 32'd0);
    check("rst_empty", 32'(empty_f), 32'd1);
    check("rst_aempty", 32'(ae_f), 32'd1);
    check("rst_full", 32'(full_f), 32'd0);
    check("rst_afull", 32'(af_f), 32'd0);
    check("rst_rvalid_f", 32'(rvalid_f), 32'd0);
    check("rst_rvalid_g", 32'(rvalid_g), 32'd0);
    check("rst_rdata_g", 32'(rdata_g), 32'd0);
    check("rst_status", 32'(status_f), 32'(MEMORY_READY));
    @(posedge clk); #1;

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(i));
      check("fill_count", 32'(count_f), 32'(i));
      check("fill_afull", 32'(af_f), 32'(i >= 6));
      check("fill_rdata_f", 32'(rdata_f), 32'h1);
    end
    check("fill_full", 32'(full_f), 32'd1);
    check("fill_rvalid_g", 32'(rvalid_g), 32'd0);
    cyc(1'b1, 1'b0, 16'h0009);
    check("ovf_status_f", 32'(status_f), 32'(MEMORY_ERROR_OUT_OF_BOUNDS));
    check("ovf_status_g", 32'(status_g), 32'(MEMORY_ERROR_OUT_OF_BOUNDS));
    check("ovf_count", 32'(count_f), 32'd8);

    // Drain, with an idle cycle after each read to see the 1-cycle rvalid pulse.
    for (int i = 1; i <= 8; i++) begin
      check("drain_rdata_f", 32'(rdata_f), 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
      check("drain_rdata_g", 32'(rdata_g), 32'(i));
      check("drain_rvalid_g", 32'(rvalid_g), 32'd1);
      check("drain_aempty", 32'(ae_f), 32'((8 - i) <= 2));
      cyc(1'b0, 1'b0, 16'h0);
      check("drain_rvalid_g_off", 32'(rvalid_g), 32'd0);
      check("drain_hold_g", 32'(rdata_g), 32'(i));
    end
    cyc(1'b0, 1'b1, 16'h0);
    check("unf_status_f", 32'(status_f), 32'(MEMORY_WAIT));
    check("unf_status_g", 32'(status_g), 32'(MEMORY_WAIT));
    check("unf_empty", 32'(empty_f), 32'd1);
    check("unf_rvalid_g", 32'(rvalid_g), 32'd0);
    check("unf_rvalid_f", 32'(rvalid_f), 32'd0);

    // Simultaneous r&w when full, then at count 3.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'h0010 + 16'(i));
    cyc(1'b1, 1'b1, 16'hAAAA);
    check("rw_full_count", 32'(count_f), 32'd7);
    check("rw_full_status", 32'(status_f), 32'(MEMORY_ERROR_OUT_OF_BOUNDS));
    check("rw_full_rdata_g", 32'(rdata_g), 32'h11);
    for (int i = 2; i <= 5; i++) begin
      check("rw_pre_rdata", 32'(rdata_f), 32'h10 + 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
    end
    check("rw3_pre_count", 32'(count_f), 32'd3);
    cyc(1'b1, 1'b1, 16'h5555);
    check("rw3_count", 32'(count_f), 32'd3);
    check("rw3_rdata_g", 32'(rdata_g), 32'h16);
    check("rw3_q0", 32'(rdata_f), 32'h17); cyc(1'b0, 1'b1, 16'h0);
    check("rw3_q1", 32'(rdata_f), 32'h18); cyc(1'b0, 1'b1, 16'h0);
    check("rw3_q2", 32'(rdata_f), 32'h5555); cyc(1'b0, 1'b1, 16'h0);
    check("rw3_empty", 32'(empty_f), 32'd1);

    // Simultaneous r&w when empty.
    cyc(1'b1, 1'b1, 16'h1234);
    check("rwe_count", 32'(count_f), 32'd1);
    check("rwe_rdata", 32'(rdata_f), 32'h1234);
    check("rwe_rvalid", 32'(rvalid_f), 32'd1);
    check("rwe_status", 32'(status_f), 32'(MEMORY_WAIT));
    cyc(1'b0, 1'b1, 16'h0);

    // Interleaved pairs walk the pointers through several wraps.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
      check("wrap_rdata", 32'(rdata_f), 32'h100 + 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
      check("wrap_rdata_g", 32'(rdata_g), 32'h100 + 32'(i));
    end
    check("wrap_count", 32'(count_f), 32'd0);

    // Flush wins over a concurrent write.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
    check("fl_pre_count", 32'(count_f), 32'd5);
    cyc(1'b0, 1'b1, 16'h0);
    check("fl_pre_rvalid_g", 32'(rvalid_g), 32'd1);
    flush = 1'b1;
    cyc(1'b1, 1'b0, 16'hBEEF);
    flush = 1'b0;
    check("fl_count", 32'(count_f), 32'd0);
    check("fl_empty", 32'(empty_f), 32'd1);
    check("fl_aempty", 32'(ae_f), 32'd1);
    check("fl_rvalid_g", 32'(rvalid_g), 32'd0);
    cyc(1'b1, 1'b0, 16'h0077);
    check("fl_after", 32'(rdata_f), 32'h77);
    check("fl_after_count", 32'(count_f), 32'd1);

    // Asynchronous reset mid-cycle with data and a registered read in flight.
    cyc(1'b1, 1'b0, 16'h0078);
    cyc(1'b1, 1'b1, 16'h0079);
    check("ar_pre_count", 32'(count_f), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("ar_count", 32'(count_f), 32'd0);
    check("ar_empty", 32'(empty_f), 32'd1);
    check("ar_rdata_f", 32'(rdata_f), 32'd0);
    check("ar_rdata_g", 32'(rdata_g), 32'd0);
    check("ar_rvalid_g", 32'(rvalid_g), 32'd0);
    check("ar_count_g", 32'(count_g), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc(1'b1, 1'b0, 16'h00AB);
    check("post_rst_count", 32'(count_f), 32'd1);
    check("post_rst_rdata", 32'(rdata_f), 32'hAB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
